seq_detector_param: RTL and testbench

Parametrised serial sequence detector. It generalises the team's fixed 4-state Mealy non-overlapping detector into one block with a compile-time pattern and length, a run-time overlap/non-overlap mode, a per-bit valid qualifier, and a saturating match counter. It sits on a serial bit stream, for example a deserialiser output or a framing-marker search, and flags each completed occurrence of the pattern with a one-cycle pulse.

---
 rtl/seq_detector_param.sv | 122 ++++++++++++
 tb/tb_seq_detector_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector with a compile-time pattern. It supports run-time
//   overlap or non-overlap matching, a per-bit valid qualifier, and a
//   saturating match counter.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_valid        qualifies i_x; unqualified cycles hold the state
//   i_x            serial data bit
//   i_overlap      1 = resume from the pattern border after a match, 0 = restart
//   i_clear        synchronous clear of the state, pulse and counter
//   o_seq_detected registered one-cycle match pulse
//   o_match_count  saturating match count
//   o_state        current matched-prefix length (debug)
module seq_detector_param #(
  parameter int unsigned        p_len     = 4,
  parameter logic [p_len-1:0]   p_pattern = 4'b1001,
  parameter int unsigned        p_cnt_w   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_x,
  input  logic                       i_overlap,
  input  logic                       i_clear,
  output logic                       o_seq_detected,
  output logic [p_cnt_w-1:0]         o_match_count,
  output logic [$clog2(p_len)-1:0]   o_state
);

  localparam int unsigned SW = $clog2(p_len);

  // Transition table, two entries per state (indexed by {k, c}).
  // Pattern bit i in arrival order is p_pattern[p_len-1-i].
  // In the final state, the entry for the matching bit is the longest
  // proper border. That entry serves as the overlap resume point.
  function automatic logic [2*p_len*SW-1:0] build_tab();
    logic [2*p_len*SW-1:0] t;
    logic [p_len-1:0]      s;
    int unsigned           res;
    logic                  ok;
    logic                  found;
    t = '0;
    for (int unsigned k = 0; k < p_len; k++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        s = '0;
        for (int unsigned i = 0; i < k; i++) s[i] = p_pattern[p_len-1-i];
        s[k]  = c[0];
        res   = 0;
        found = 1'b0;
        if ((k < p_len - 1) && (c[0] == p_pattern[p_len-1-k])) begin
          res   = k + 1;
          found = 1'b1;
        end
        // Longest proper suffix of s[0..k] that is also a pattern prefix.
        for (int unsigned j = k; j >= 1; j--) begin
          if (!found) begin
            ok = 1'b1;
            for (int unsigned m = 0; m < j; m++) begin
              if (s[k+1-j+m] != p_pattern[p_len-1-m]) ok = 1'b0;
            end
            if (ok) begin
              res   = j;
              found = 1'b1;
            end
          end
        end
        t[(2*k+c)*SW +: SW] = SW'(res);
      end
    end
    return t;
  endfunction

  localparam logic [2*p_len*SW-1:0] TAB    = build_tab();
  localparam logic [SW-1:0]         LAST   = SW'(p_len - 1);
  localparam logic [SW-1:0]         BORDER = TAB[(2*(p_len-1) + int'(p_pattern[0]))*SW +: SW];

  logic [SW-1:0]      tab [2*p_len];
  logic [SW-1:0]      state_q, state_d;
  logic               det_q, det_d;
  logic [p_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int unsigned i = 0; i < 2 * p_len; i++) tab[i] = TAB[i*SW +: SW];
  end

  always_comb begin
    state_d = state_q;
    det_d   = 1'b0;
    cnt_d   = cnt_q;
    if (i_clear) begin
      state_d = '0;
      cnt_d   = '0;
    end else if (i_valid) begin
      if ((state_q == LAST) && (i_x == p_pattern[0])) begin
        det_d   = 1'b1;
        state_d = i_overlap ? BORDER : '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        state_d = tab[{state_q, i_x}];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= '0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_seq_detected = det_q;
  assign o_match_count  = cnt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. It uses three instances:
//   A: pattern 1001, 8-bit counter
//   B: pattern 1010 (border 2)
//   C: pattern 11 with a 4-bit counter (saturation)
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A
  logic       a_rst, a_valid, a_x, a_ovl, a_clr;
  logic       a_det;
  logic [7:0] a_cnt;
  logic [1:0] a_st;
  // Instance B
  logic       b_rst, b_valid, b_x, b_ovl, b_clr;
  logic       b_det;
  logic [7:0] b_cnt;
  logic [1:0] b_st;
  // Instance C
  logic       c_rst, c_valid, c_x, c_ovl, c_clr;
  logic       c_det;
  logic [3:0] c_cnt;
  logic [0:0] c_st;

  seq_detector_param #(.p_len(4), .p_pattern(4'b1001), .p_cnt_w(8)) u_a (
    .i_clk(clk), .i_reset(a_rst), .i_valid(a_valid), .i_x(a_x), .i_overlap(a_ovl),
    .i_clear(a_clr), .o_seq_detected(a_det), .o_match_count(a_cnt), .o_state(a_st));

  seq_detector_param #(.p_len(4), .p_pattern(4'b1010), .p_cnt_w(8)) u_b (
    .i_clk(clk), .i_reset(b_rst), .i_valid(b_valid), .i_x(b_x), .i_overlap(b_ovl),
    .i_clear(b_clr), .o_seq_detected(b_det), .o_match_count(b_cnt), .o_state(b_st));

  seq_detector_param #(.p_len(2), .p_pattern(2'b11), .p_cnt_w(4)) u_c (
    .i_clk(clk), .i_reset(c_rst), .i_valid(c_valid), .i_x(c_x), .i_overlap(c_ovl),
    .i_clear(c_clr), .o_seq_detected(c_det), .o_match_count(c_cnt), .o_state(c_st));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge on instance A; inputs return to idle afterwards.
  task automatic a_step(input logic v, input logic x, input logic clr);
    a_valid = v; a_x = x; a_clr = clr;
    @(posedge clk); #1;
    a_valid = 1'b0; a_x = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_step(input logic v, input logic x, input logic clr);
    b_valid = v; b_x = x; b_clr = clr;
    @(posedge clk); #1;
    b_valid = 1'b0; b_x = 1'b0; b_clr = 1'b0;
  endtask

  task automatic c_step(input logic v, input logic x);
    c_valid = v; c_x = x;
    @(posedge clk); #1;
    c_valid = 1'b0; c_x = 1'b0;
  endtask

  logic [6:0]  s7;
  logic [6:0]  p7;
  logic [3:0]  s4;
  logic [3:0]  p4;
  logic [5:0]  s6;
  logic [5:0]  p6;
  int          exp_cnt;

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_x = 1'b0; a_ovl = 1'b1; a_clr = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_x = 1'b0; b_ovl = 1'b1; b_clr = 1'b0;
    c_rst = 1'b1; c_valid = 1'b0; c_x = 1'b0; c_ovl = 1'b1; c_clr = 1'b0;
    #1;
    chk("rst_a_det", int'(a_det), 0);
    chk("rst_a_cnt", int'(a_cnt), 0);
    chk("rst_a_st",  int'(a_st),  0);
    chk("rst_c_cnt", int'(c_cnt), 0);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // A, overlap: 1001001 -> pulses after bits 4 and 7 (MSB first in vectors)
    s7 = 7'b1001001; p7 = 7'b0001001;
    a_ovl = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      a_step(1'b1, s7[i], 1'b0);
      chk($sformatf("a_ovl_det_b%0d", 7 - i), int'(a_det), int'(p7[i]));
    end
    chk("a_ovl_cnt", int'(a_cnt), 2);
    chk("a_ovl_st_border", int'(a_st), 1);

    a_step(1'b0, 1'b0, 1'b1);
    chk("a_clr_st",  int'(a_st),  0);
    chk("a_clr_cnt", int'(a_cnt), 0);
    chk("a_clr_det", int'(a_det), 0);

    // A, non-overlap: 1001001 then 1001 -> pulses after bits 4 and 11
    a_ovl = 1'b0;
    p7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      a_step(1'b1, s7[i], 1'b0);
      chk($sformatf("a_novl_det_b%0d", 7 - i), int'(a_det), int'(p7[i]));
    end
    chk("a_novl_cnt1", int'(a_cnt), 1);
    s4 = 4'b1001; p4 = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      a_step(1'b1, s4[i], 1'b0);
      chk($sformatf("a_novl_det_b%0d", 11 - i), int'(a_det), int'(p4[i]));
    end
    chk("a_novl_cnt2", int'(a_cnt), 2);

    // A, gap cycles between bits: state holds, no pulse on gaps
    a_step(1'b0, 1'b0, 1'b1);
    a_ovl = 1'b1;
    a_step(1'b1, 1'b1, 1'b0); chk("gap_st1", int'(a_st), 1);
    a_step(1'b0, 1'b1, 1'b0); chk("gap_st1h", int'(a_st), 1); chk("gap_det1", int'(a_det), 0);
    a_step(1'b1, 1'b0, 1'b0); chk("gap_st2", int'(a_st), 2);
    a_step(1'b0, 1'b1, 1'b0); chk("gap_st2h", int'(a_st), 2); chk("gap_det2", int'(a_det), 0);
    a_step(1'b1, 1'b0, 1'b0); chk("gap_st3", int'(a_st), 3);
    a_step(1'b0, 1'b1, 1'b0); chk("gap_st3h", int'(a_st), 3); chk("gap_det3", int'(a_det), 0);
    a_step(1'b1, 1'b1, 1'b0); chk("gap_det4", int'(a_det), 1); chk("gap_cnt", int'(a_cnt), 1);
    a_step(1'b0, 1'b1, 1'b0); chk("gap_det4h", int'(a_det), 0); chk("gap_st4h", int'(a_st), 1);

    // A, reset mid-sequence, asserted between edges
    a_step(1'b1, 1'b1, 1'b0);
    a_step(1'b1, 1'b0, 1'b0);
    a_step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_st", int'(a_st), 3);
    #2 a_rst = 1'b1;
    #1;
    chk("mid_rst_st",  int'(a_st),  0);
    chk("mid_rst_cnt", int'(a_cnt), 0);
    chk("mid_rst_det", int'(a_det), 0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_step(1'b1, 1'b1, 1'b0);
    chk("post_rst_det", int'(a_det), 0);
    chk("post_rst_st",  int'(a_st),  1);

    // A, clear on the final bit drops the match
    a_step(1'b1, 1'b0, 1'b0);
    a_step(1'b1, 1'b0, 1'b0);
    a_step(1'b1, 1'b1, 1'b1);
    chk("clr_final_det", int'(a_det), 0);
    chk("clr_final_cnt", int'(a_cnt), 0);
    chk("clr_final_st",  int'(a_st),  0);

    // B, pattern 1010 overlap: 101010 -> pulses after bits 4 and 6
    s6 = 6'b101010; p6 = 6'b000101;
    b_ovl = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      b_step(1'b1, s6[i], 1'b0);
      chk($sformatf("b_ovl_det_b%0d", 6 - i), int'(b_det), int'(p6[i]));
    end
    chk("b_ovl_cnt", int'(b_cnt), 2);
    b_step(1'b0, 1'b0, 1'b1);
    b_ovl = 1'b0;
    p6 = 6'b000100;
    for (int i = 5; i >= 0; i--) begin
      b_step(1'b1, s6[i], 1'b0);
      chk($sformatf("b_novl_det_b%0d", 6 - i), int'(b_det), int'(p6[i]));
    end
    chk("b_novl_st", int'(b_st), 2);
    chk("b_novl_cnt", int'(b_cnt), 1);

    // C, pattern 11 overlap: 20 ones -> 19 consecutive pulses, count saturates at 15
    c_ovl = 1'b1;
    exp_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      c_step(1'b1, 1'b1);
      if (i > 1 && exp_cnt < 15) exp_cnt++;
      chk($sformatf("c_det_b%0d", i), int'(c_det), (i > 1) ? 1 : 0);
      chk($sformatf("c_cnt_b%0d", i), int'(c_cnt), exp_cnt);
    end
    c_step(1'b0, 1'b1);
    chk("c_det_idle", int'(c_det), 0);
    chk("c_cnt_hold", int'(c_cnt), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
